// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: parity-width sizing, data-bit placement and the
// output buffer state encoding used by the encoder (and later the decoder).
package hamming_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    // Smallest r with 2^r >= data_w + r + 1; scanned downwards so the last hit wins.
    function automatic int calc_par_w(input int data_w);
        int r;
        r = 32'sd7;
        for (int k = 32'sd7; k >= 32'sd1; k--) begin
            if ((32'sd1 << k) >= (data_w + k + 32'sd1)) begin
                r = k;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Hamming position of data bit idx: the idx-th position that is not a power of two.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 32'sd0;
        pos = 32'sd0;
        for (int p = 32'sd1; p < 32'sd128; p++) begin
            if ((p & (p - 32'sd1)) != 32'sd0) begin
                if (cnt == idx) begin
                    pos = p;
                end else begin
                    pos = pos;
                end
                cnt = cnt + 32'sd1;
            end else begin
                cnt = cnt;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_calc.sv
// Combinational Hamming codeword builder; shared with the decoder syndrome path.
// SECDED=1 puts position i on bit i with overall parity on bit 0, else position i on bit i-1.
module hamming_calc
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int SECDED = 1,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int N_POS  = DATA_W + PAR_W,
    localparam int CODE_W = N_POS + SECDED
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [CODE_W-1:0] o_code
);

    logic [N_POS:1] w_pos;

    // Scatter data bits, then fold each covered data position into its parity bit.
    always_comb begin
        w_pos = '0;
        for (int d = 0; d < DATA_W; d++) begin
            w_pos[data_pos(d)] = i_data[d];
        end
        for (int k = 0; k < PAR_W; k++) begin
            for (int p = 1; p <= N_POS; p++) begin
                w_pos[32'sd1 << k] = w_pos[32'sd1 << k]
                    ^ (w_pos[p] & (((p >> k) & 32'sd1) == 32'sd1) & (p != (32'sd1 << k)));
            end
        end
    end

    generate
        if (SECDED != 0) begin : g_secded
            assign o_code = {w_pos, ^w_pos};
        end else begin : g_sec
            assign o_code = w_pos;
        end
    endgenerate

endmodule

// File: rtl/hamming_secded_enc.sv
// Valid/ready Hamming (SEC or SECDED) encoder with a 2-entry elastic output
// buffer, single-bit error injection and a saturating emitted-codeword count.
module hamming_secded_enc
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int SECDED = 1,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + SECDED,
    localparam int POS_W  = $clog2(CODE_W)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              inj_en,
    input  logic [POS_W-1:0]  inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] data_out,
    output logic [CNT_W-1:0]  cw_count
);

    buf_state_e        r_state;
    buf_state_e        w_state_nxt;
    logic [CODE_W-1:0] r_main;
    logic [CODE_W-1:0] r_skid;
    logic [CODE_W-1:0] w_main_nxt;
    logic [CODE_W-1:0] w_skid_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic [CODE_W-1:0] w_code;
    logic [CODE_W-1:0] w_flip;
    logic [CODE_W-1:0] w_enc;
    logic              w_in_xfer;
    logic              w_out_xfer;

    hamming_calc #(
        .DATA_W (DATA_W),
        .SECDED (SECDED)
    ) u_calc (
        .i_data (data_in),
        .o_code (w_code)
    );

    // A shift past the top bit yields zero, so out-of-range positions flip nothing.
    assign w_flip     = {{(CODE_W-1){1'b0}}, inj_en} << inj_pos;
    assign w_enc      = w_code ^ w_flip;
    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // Buffer occupancy transitions and main/skid next contents.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ONE;
                    w_main_nxt  = w_enc;
                end else begin
                    w_state_nxt = EMPTY;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_nxt = w_enc;
                end else if (w_in_xfer) begin
                    w_state_nxt = FULL;
                    w_skid_nxt  = w_enc;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end else begin
                    w_state_nxt = ONE;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_state_nxt = ONE;
                    w_main_nxt  = r_skid;
                end else begin
                    w_state_nxt = FULL;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // State, buffer contents, registered handshakes and the saturating counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != FULL);
            r_out_valid <= (w_state_nxt != EMPTY);
            if (w_out_xfer && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_main;
    assign cw_count  = r_cnt;

endmodule

// File: tb/tb_hamming_secded_enc.sv
// Directed bench for hamming_secded_enc: a 4-bit SECDED instance, a CNT_W=2
// twin sharing its inputs, and an 11-bit SEC instance for injection syndromes.
module tb_hamming_secded_enc;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, inj_en, out_ready;
    logic [3:0]  data_in;
    logic [2:0]  inj_pos;
    logic        in_ready, out_valid;
    logic [7:0]  data_out;
    logic [15:0] cw_count;
    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_data_out;
    logic [1:0]  s_cw_count;
    logic        wd_in_valid, wd_inj_en, wd_out_ready, wd_in_ready, wd_out_valid;
    logic [10:0] wd_data_in;
    logic [3:0]  wd_inj_pos;
    logic [14:0] wd_data_out;
    logic [15:0] wd_cw_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hamming_secded_enc #(.DATA_W(4), .SECDED(1), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .cw_count(cw_count));

    hamming_secded_enc #(.DATA_W(4), .SECDED(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s_in_ready),
        .data_in(data_in), .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(s_out_valid), .out_ready(out_ready), .data_out(s_data_out),
        .cw_count(s_cw_count));

    hamming_secded_enc #(.DATA_W(11), .SECDED(0), .CNT_W(16)) dut_wide (
        .clk(clk), .rstn(rstn), .in_valid(wd_in_valid), .in_ready(wd_in_ready),
        .data_in(wd_data_in), .inj_en(wd_inj_en), .inj_pos(wd_inj_pos),
        .out_valid(wd_out_valid), .out_ready(wd_out_ready), .data_out(wd_data_out),
        .cw_count(wd_cw_count));

    // Reference: parity vector is the XOR of the positions holding a 1 data bit.
    function automatic logic [7:0] ref_enc4(input logic [3:0] d);
        logic [7:0] cw;
        logic [2:0] syn;
        int di;
        cw = 8'h00; syn = 3'd0; di = 0;
        for (int p = 1; p < 8; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[di];
                if (d[di]) syn = syn ^ 3'(p);
                di++;
            end
        end
        cw[1] = syn[0]; cw[2] = syn[1]; cw[4] = syn[2];
        cw[0] = ^cw[7:1];
        return cw;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; inj_en = 1'b0; out_ready = 1'b0;
        data_in = 4'h0; inj_pos = 3'd0;
        wd_in_valid = 1'b0; wd_inj_en = 1'b0; wd_out_ready = 1'b1;
        wd_data_in = 11'h000; wd_inj_pos = 4'd0;
        #12;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_cmp++; if (cw_count !== 16'd0) begin n_err++; $display("FAIL reset_cw_count: got %0d want 0", cw_count); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        out_ready = 1'b1; in_valid = 1'b1; data_in = 4'hB;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_cmp++; if (data_out !== 8'hAA) begin n_err++; $display("FAIL basic_B: got %h want aa", data_out); end
        data_in = 4'h0;
        @(negedge clk);
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL basic_0: got %h want 00", data_out); end
        data_in = 4'hF;
        @(negedge clk);
        n_cmp++; if (data_out !== 8'hFF) begin n_err++; $display("FAIL basic_F: got %h want ff", data_out); end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (cw_count !== 16'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", cw_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_inject();
        in_valid = 1'b1; data_in = 4'hB; inj_en = 1'b1; inj_pos = 3'd3;
        @(negedge clk);
        n_cmp++; if (data_out !== 8'hA2) begin n_err++; $display("FAIL inject_pos3: got %h want a2", data_out); end
        inj_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (data_out !== 8'hAA) begin n_err++; $display("FAIL inject_off: got %h want aa", data_out); end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (cw_count !== 16'd5) begin n_err++; $display("FAIL inject_count: got %0d want 5", cw_count); end
        n_cmp++; if (s_cw_count !== 2'd3) begin n_err++; $display("FAIL sat_count5: got %0d want 3", s_cw_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; data_in = 4'h1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one: got %b want 1", in_ready); end
        n_cmp++; if (data_out !== 8'h0F) begin n_err++; $display("FAIL bp_first: got %h want 0f", data_out); end
        data_in = 4'h2;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        n_cmp++; if (data_out !== 8'h0F) begin n_err++; $display("FAIL bp_hold1: got %h want 0f", data_out); end
        data_in = 4'h3;
        @(negedge clk);
        n_cmp++; if (data_out !== 8'h0F) begin n_err++; $display("FAIL bp_hold2: got %h want 0f", data_out); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (data_out !== 8'h33) begin n_err++; $display("FAIL bp_second: got %h want 33", data_out); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        n_cmp++; if (cw_count !== 16'd7) begin n_err++; $display("FAIL bp_count: got %0d want 7", cw_count); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; data_in = 4'($urandom); prev = data_in;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            n_cmp++; if (data_out !== ref_enc4(prev)) begin n_err++; $display("FAIL stream_%0d: got %h want %h", i, data_out, ref_enc4(prev)); end
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL stream_hs_%0d: got v=%b r=%b want 1 1", i, out_valid, in_ready); end
            data_in = 4'($urandom); prev = data_in;
            if (i == 100) in_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (cw_count !== 16'd100) begin n_err++; $display("FAIL stream_count: got %0d want 100", cw_count); end
        n_cmp++; if (s_cw_count !== 2'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", s_cw_count); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; data_in = 4'h5;
        @(negedge clk);
        data_in = 4'h6;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ar_full: got %b want 0", in_ready); end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready: got %b want 1", in_ready); end
        n_cmp++; if (cw_count !== 16'd0) begin n_err++; $display("FAIL ar_count: got %0d want 0", cw_count); end
        n_cmp++; if (s_cw_count !== 2'd0) begin n_err++; $display("FAIL ar_sat_count: got %0d want 0", s_cw_count); end
        @(negedge clk);
        rstn = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_discard: got %b want 0", out_valid); end
    endtask

    task automatic test_injection_syndrome();
        logic [10:0] words [3];
        logic [3:0]  syn;
        logic [3:0]  exp_syn;
        logic [10:0] dat;
        int          k;
        words[0] = 11'h000; words[1] = 11'h7FF; words[2] = 11'h5A3;
        for (int w = 0; w < 3; w++) begin
            for (int p = 0; p < 16; p++) begin
                wd_in_valid = 1'b1; wd_inj_en = 1'b1; wd_inj_pos = 4'(p); wd_data_in = words[w];
                @(negedge clk);
                syn = 4'd0;
                for (int i = 0; i < 15; i++) if (wd_data_out[i]) syn = syn ^ 4'(i + 1);
                exp_syn = (p < 15) ? 4'(p + 1) : 4'd0;
                n_cmp++; if (syn !== exp_syn || wd_out_valid !== 1'b1) begin n_err++; $display("FAIL wide_syn_w%0d_p%0d: got syn=%0d v=%b want syn=%0d v=1", w, p, syn, wd_out_valid, exp_syn); end
                if (p == 15) begin
                    dat = 11'h000; k = 0;
                    for (int i = 0; i < 15; i++) if (((i + 1) & i) != 0) begin dat[k] = wd_data_out[i]; k++; end
                    n_cmp++; if (dat !== words[w]) begin n_err++; $display("FAIL wide_data_w%0d: got %h want %h", w, dat, words[w]); end
                end
            end
        end
        wd_in_valid = 1'b0; wd_inj_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (wd_cw_count !== 16'd48) begin n_err++; $display("FAIL wide_count: got %0d want 48", wd_cw_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inject();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_injection_syndrome();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
